// File: rtl/quad_encoder_counter_pkg.sv
// Shared types and helpers for the quadrature encoder counter.
package quad_enc_pkg;

  // Encoder states, named by their {a, b} bit pattern
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  // Upper-case hex character for one nibble
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASCII_ZERO + {4'b0000, n};
    end
    return ASCII_A + {4'b0000, n} - 8'd10;
  endfunction

  // Classify a state transition as {valid, up, illegal}.
  // The up direction walks 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [2:0] step_dir(input quad_state_t prev, input quad_state_t cur);
    logic [2:0] res;
    res = 3'b000;
    case ({prev, cur})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: res = 3'b110;
      {Q01, Q00}, {Q11, Q01}, {Q10, Q11}, {Q00, Q10}: res = 3'b100;
      {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: res = 3'b001;
      default:                                        res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_encoder_counter_if.sv
// Encoder pins, clear request and counter outputs bundled as one bus.
interface quad_encoder_counter_if #(
  parameter int CNT_W = 12
);
  logic             a;
  logic             b;
  logic             clear;
  logic [CNT_W-1:0] count;
  logic             step_valid;
  logic             dir;
  logic             err;
  logic [11:0]      rotary_value;

  // Driver side: owns the pins and clear, observes the counter
  modport master (
    output a, b, clear,
    input  count, step_valid, dir, err, rotary_value
  );

  // Counter side
  modport slave (
    input  a, b, clear,
    output count, step_valid, dir, err, rotary_value
  );
endinterface

// File: rtl/quad_encoder_counter_filter.sv
// Synchroniser plus debounce for one raw encoder pin.
module encoder_input_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CTR_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CTR_W-1:0]       db_cnt;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  // Plain flop chain into the clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      filtered <= 1'b0;
    end else if (synced != filtered) begin
      if (db_cnt == CTR_LAST) begin
        filtered <= synced;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CTR_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder: filtered A/B -> x4 position count, step strobe and ASCII digit.
module quad_encoder_counter
  import quad_enc_pkg::*;
#(
  parameter int CNT_W           = 12,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SATURATE        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  quad_encoder_counter_if.slave bus
);

  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  logic             a_f;
  logic             b_f;
  quad_state_t      prev_state;
  quad_state_t      cur_state;
  logic             step_ok;
  logic             step_up;
  logic             step_bad;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             step_valid_reg;
  logic             dir_reg;
  logic             err_reg;
  logic [11:0]      rotary_reg;

  encoder_input_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter_a (
    .clk     (clk),
    .reset   (reset),
    .raw     (bus.a),
    .filtered(a_f)
  );

  encoder_input_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter_b (
    .clk     (clk),
    .reset   (reset),
    .raw     (bus.b),
    .filtered(b_f)
  );

  assign cur_state = quad_state_t'({a_f, b_f});
  assign {step_ok, step_up, step_bad} = step_dir(prev_state, cur_state);

  // Next count: wrap or clamp on a step, clear overrides everything
  always_comb begin
    count_next = count_reg;
    if (step_ok) begin
      if (step_up) begin
        if (!(SATURATE != 0 && count_reg == COUNT_MAX)) begin
          count_next = count_reg + CNT_W'(1);
        end
      end else begin
        if (!(SATURATE != 0 && count_reg == '0)) begin
          count_next = count_reg - CNT_W'(1);
        end
      end
    end
    if (bus.clear) begin
      count_next = '0;
    end
  end

  // Decode state and registered outputs; rotary_value tracks the new count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_state     <= Q00;
      count_reg      <= '0;
      step_valid_reg <= 1'b0;
      dir_reg        <= 1'b0;
      err_reg        <= 1'b0;
      rotary_reg     <= 12'h030;
    end else begin
      prev_state     <= cur_state;
      step_valid_reg <= step_ok;
      err_reg        <= step_bad;
      if (step_ok) begin
        dir_reg <= step_up;
      end
      count_reg  <= count_next;
      rotary_reg <= {4'b0000, hex_to_ascii(count_next[3:0])};
    end
  end

  assign bus.count        = count_reg;
  assign bus.step_valid   = step_valid_reg;
  assign bus.dir          = dir_reg;
  assign bus.err          = err_reg;
  assign bus.rotary_value = rotary_reg;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Bench: wrap and saturate instances driven in parallel, checked against a pin-level model.
module tb_quad_encoder_counter;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_drv = 1'b0;
  logic b_drv = 1'b0;
  logic clear_drv = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  quad_encoder_counter_if #(.CNT_W(12)) bus0 ();
  quad_encoder_counter_if #(.CNT_W(12)) bus1 ();

  assign bus0.a = a_drv;
  assign bus0.b = b_drv;
  assign bus0.clear = clear_drv;
  assign bus1.a = a_drv;
  assign bus1.b = b_drv;
  assign bus1.clear = clear_drv;

  quad_encoder_counter #(.CNT_W(12), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .SATURATE(0)) dut_wrap (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  quad_encoder_counter #(.CNT_W(12), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .SATURATE(1)) dut_sat (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position around the cycle 00,01,11,10, indexed by the {a,b} value
  int pos_of [4] = '{0, 1, 3, 2};

  logic [1:0]  raw_q [$];
  logic [1:0]  syn_q [$];
  logic [26:0] exp0_q [$];
  logic [26:0] exp1_q [$];
  logic [1:0]  m_filt;
  logic [1:0]  m_prev;
  logic        m_dir;
  int          m_c0;
  int          m_c1;
  logic [1:0]  m_synced;
  int          m_d;
  bit          m_sv;
  bit          m_er;
  bit          m_all;

  function automatic logic [11:0] rot_of(input int c);
    int n;
    n = c & 15;
    if (n < 10) return 12'(48 + n);
    return 12'(65 + n - 10);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      raw_q.delete();
      syn_q.delete();
      for (int i = 0; i < SYNC; i++) raw_q.push_back(2'b00);
      m_filt = 2'b00;
      m_prev = 2'b00;
      m_dir  = 1'b0;
      m_c0   = 0;
      m_c1   = 0;
      exp0_q.push_back({1'b0, 1'b0, 1'b0, 12'd0, 12'h030});
      exp1_q.push_back({1'b0, 1'b0, 1'b0, 12'd0, 12'h030});
    end else begin
      // level the debouncer sees this cycle = pin value SYNC samples ago
      m_synced = raw_q.pop_front();
      raw_q.push_back({a_drv, b_drv});
      // decode the filtered state as it stood before this edge
      m_d  = (pos_of[m_filt] - pos_of[m_prev] + 4) % 4;
      m_sv = (m_d == 1) || (m_d == 3);
      m_er = (m_d == 2);
      if (m_sv) begin
        m_dir = (m_d == 1);
        if (m_dir) begin
          m_c0 = (m_c0 + 1) % 4096;
          m_c1 = (m_c1 == 4095) ? 4095 : m_c1 + 1;
        end else begin
          m_c0 = (m_c0 + 4095) % 4096;
          m_c1 = (m_c1 == 0) ? 0 : m_c1 - 1;
        end
      end
      if (clear_drv) begin
        m_c0 = 0;
        m_c1 = 0;
      end
      m_prev = m_filt;
      // a filtered bit flips once the last DEB seen levels all disagree with it
      syn_q.push_back(m_synced);
      if (syn_q.size() > DEB) void'(syn_q.pop_front());
      if (syn_q.size() == DEB) begin
        for (int ch = 0; ch < 2; ch++) begin
          m_all = 1'b1;
          foreach (syn_q[i]) if (syn_q[i][ch] == m_filt[ch]) m_all = 1'b0;
          if (m_all) m_filt[ch] = ~m_filt[ch];
        end
      end
      exp0_q.push_back({m_sv, m_er, m_dir, 12'(m_c0), rot_of(m_c0)});
      exp1_q.push_back({m_sv, m_er, m_dir, 12'(m_c1), rot_of(m_c1)});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: got no expected entry, expected one per cycle (t=%0t)", $time);
    end else begin
      check("sb_wrap {sv,err,dir,count,rot}",
            32'({bus0.step_valid, bus0.err, bus0.dir, bus0.count, bus0.rotary_value}),
            32'(exp0_q.pop_front()));
      check("sb_sat {sv,err,dir,count,rot}",
            32'({bus1.step_valid, bus1.err, bus1.dir, bus1.count, bus1.rotary_value}),
            32'(exp1_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; sets pins and holds for cyc falling edges
  task automatic drive(input logic [1:0] ab, input int cyc, input bit clr = 1'b0);
    a_drv = ab[1];
    b_drv = ab[0];
    for (int i = 0; i < cyc; i++) begin
      clear_drv = (i == 0) ? clr : 1'b0;
      @(negedge clk);
    end
    clear_drv = 1'b0;
  endtask

  task automatic watch(input int cyc, output int ns, output int ne);
    ns = 0;
    ne = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (bus0.step_valid) ns++;
      if (bus0.err) ne++;
    end
  endtask

  logic [1:0] up_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int ns, ne, lat;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    watch(20, ns, ne);
    check("idle_steps", ns, 0);
    check("idle_errs", ne, 0);
    check("idle_count", bus0.count, 0);
    check("idle_rot", bus0.rotary_value, 12'h030);
    $display("[TB] reset/idle done");

    // full up cycle with latency measurement on the first step
    a_drv = 1'b0;
    b_drv = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus0.step_valid) begin
        lat = k;
        break;
      end
    end
    check("first_step_latency", lat, 7);
    repeat (5) @(negedge clk);
    drive(2'b11, 10);
    drive(2'b10, 10);
    drive(2'b00, 10);
    check("up_count", bus0.count, 4);
    check("up_rot", bus0.rotary_value, 12'h034);
    check("up_dir", bus0.dir, 1);
    check("up_count_sat", bus1.count, 4);
    $display("[TB] up cycle done");

    // down cycle from zero
    drive(2'b00, 2, 1'b1);
    drive(2'b10, 10);
    drive(2'b11, 10);
    drive(2'b01, 10);
    drive(2'b00, 10);
    check("down_count_wrap", bus0.count, 12'hffc);
    check("down_rot_wrap", bus0.rotary_value, 12'h043);
    check("down_dir", bus0.dir, 0);
    check("down_count_sat", bus1.count, 0);
    check("down_dir_sat", bus1.dir, 0);
    $display("[TB] down cycle done");

    // glitches: 3-cycle pulse rejected, 4-cycle pulse accepted both ways
    drive(2'b10, 3);
    drive(2'b00, 0);
    watch(15, ns, ne);
    check("glitch3_steps", ns, 0);
    drive(2'b10, 4);
    drive(2'b00, 0);
    watch(20, ns, ne);
    check("pulse4_steps", ns, 2);
    check("pulse4_errs", ne, 0);
    $display("[TB] glitch tests done");

    // both pins change together
    drive(2'b11, 0);
    watch(15, ns, ne);
    check("double_errs", ne, 1);
    check("double_steps", ns, 0);
    drive(2'b00, 15);
    $display("[TB] illegal transition done");

    // random pins and clears
    for (int r = 0; r < 300; r++) begin
      drive(2'($urandom_range(0, 3)), $urandom_range(1, 12), ($urandom_range(0, 15) == 0));
    end
    drive(2'b00, 15, 1'b1);
    $display("[TB] random phase done");

    // count to 9, then clear on the same edge as the 10th step
    for (int s = 1; s <= 9; s++) drive(up_seq[s % 4], 10);
    check("count_nine", bus0.count, 9);
    a_drv = 1'b1;
    b_drv = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    clear_drv = 1'b1;
    @(negedge clk);
    clear_drv = 1'b0;
    check("clr_step_valid", bus0.step_valid, 1);
    check("clr_dir", bus0.dir, 1);
    check("clr_count", bus0.count, 0);
    check("clr_rot", bus0.rotary_value, 12'h030);
    drive(2'b11, 10);
    $display("[TB] clear-vs-step done");

    // async reset in the middle of a transition, encoder parked at 11
    drive(2'b10, 10);
    drive(2'b00, 3);
    #2;
    reset = 1'b1;
    a_drv = 1'b1;
    b_drv = 1'b1;
    #1;
    check("areset_count", bus0.count, 0);
    check("areset_sv", bus0.step_valid, 0);
    check("areset_dir", bus0.dir, 0);
    check("areset_err", bus0.err, 0);
    check("areset_rot", bus0.rotary_value, 12'h030);
    check("areset_count_sat", bus1.count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    watch(20, ns, ne);
    check("post_reset_errs", ne, 1);
    check("post_reset_steps", ns, 0);
    $display("[TB] async reset done");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
